// File: rtl/fsb_pkg.sv
// Shared widths and types for the FSB-to-host transmit path.
// Clients send 80-bit packets. Each packet is zero-padded to 128 bits and sent as 32-bit words.
package fsb_pkg;

    localparam int fsb_ring_width_gp = 80;
    localparam int fsb_axis_width_gp = 32;
    localparam int fsb_pkt_beats_gp  = 4;
    localparam int fsb_pad_width_gp  = fsb_axis_width_gp * fsb_pkt_beats_gp;

    typedef logic [fsb_ring_width_gp-1:0] fsb_pkt_s;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsb_tx_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter. It makes a combinational one-hot grant from reqs_i.
// The priority pointer moves past the winner only when yumi_i accepts the grant.
module bsg_arb_round_robin #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] reqs_i,
    output logic [width_p-1:0] grants_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (width_p > 1) ? $clog2(width_p) : 1;

    logic [ptr_w_lp-1:0] ptr_q, ptr_d;
    logic [ptr_w_lp-1:0] winner_w;
    logic                found_w;
    int                  idx_w;

    // Scan upward from the pointer with wrap; first requester wins
    always_comb begin
        grants_o = '0;
        winner_w = '0;
        found_w  = 1'b0;
        idx_w    = 0;
        for (int i = 0; i < width_p; i++) begin
            idx_w = int'(ptr_q) + i;
            if (idx_w >= width_p) begin
                idx_w = idx_w - width_p;
            end else begin
                idx_w = idx_w;
            end
            if (!found_w && reqs_i[idx_w]) begin
                found_w          = 1'b1;
                winner_w         = ptr_w_lp'(idx_w);
                grants_o[idx_w]  = 1'b1;
            end else begin
                found_w = found_w;
            end
        end
    end

    // Pointer next-state: one past the accepted winner
    always_comb begin
        ptr_d = ptr_q;
        if (yumi_i && found_w) begin
            if (winner_w == ptr_w_lp'(width_p - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner_w + 1'b1;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fsb_host_tx_arbiter.sv
// Picks one client packet with round-robin arbitration and sends it to the host stream.
// The padded 128-bit packet goes out as four words, least-significant word first.
module fsb_host_tx_arbiter
    import fsb_pkg::*;
#(
    parameter int num_clients_p = 4,
    parameter int ring_width_p  = fsb_ring_width_gp,
    parameter int axis_width_p  = fsb_axis_width_gp
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_clients_p-1:0]              v_i,
    input  logic [num_clients_p*ring_width_p-1:0] data_i,
    output logic [num_clients_p-1:0]              yumi_o,
    output logic                                  axis_tvalid_o,
    input  logic                                  axis_tready_i,
    output logic [axis_width_p-1:0]               axis_tdata_o,
    output logic                                  axis_tlast_o,
    output logic [$clog2(num_clients_p)-1:0]      grant_id_o,
    output logic [31:0]                           pkt_count_o
);

    localparam int beats_lp  = fsb_pad_width_gp / axis_width_p;
    localparam int beat_w_lp = $clog2(beats_lp);
    localparam int id_w_lp   = $clog2(num_clients_p);
    localparam int pad_lp    = fsb_pad_width_gp - ring_width_p;

    fsb_tx_state_e               state_q, state_d;
    logic [beat_w_lp-1:0]        beat_q, beat_d;
    logic [fsb_pad_width_gp-1:0] pkt_q, pkt_d;
    logic [id_w_lp-1:0]          grant_id_q, grant_id_d;
    logic [31:0]                 pkt_count_q, pkt_count_d;

    logic [num_clients_p-1:0]    grants_w;
    logic [id_w_lp-1:0]          winner_w;
    logic                        hs_w, last_w, accept_w, grant_w;

    assign hs_w     = (state_q == SEND) & axis_tready_i;
    assign last_w   = (state_q == SEND) & (beat_q == beat_w_lp'(beats_lp - 1));
    // Reset blocks acceptance: a packet consumed during reset would otherwise be lost
    assign accept_w = ~reset_i & ((state_q == IDLE) | (last_w & axis_tready_i));
    assign grant_w  = accept_w & (|v_i);

    bsg_arb_round_robin #(
        .width_p (num_clients_p)
    ) u_arb (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .reqs_i   (v_i),
        .grants_o (grants_w),
        .yumi_i   (grant_w)
    );

    assign yumi_o = grant_w ? grants_w : '0;

    // One-hot grant to client index
    always_comb begin
        winner_w = '0;
        for (int i = 0; i < num_clients_p; i++) begin
            if (grants_w[i]) begin
                winner_w = id_w_lp'(i);
            end else begin
                winner_w = winner_w;
            end
        end
    end

    // Serializer next-state: beat advance, delivery count, packet load
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        pkt_d       = pkt_q;
        grant_id_d  = grant_id_q;
        pkt_count_d = pkt_count_q;
        if (hs_w) begin
            beat_d = beat_q + 1'b1;
            if (last_w) begin
                pkt_count_d = pkt_count_q + 32'd1;
            end else begin
                pkt_count_d = pkt_count_q;
            end
        end else begin
            beat_d = beat_q;
        end
        if (grant_w) begin
            pkt_d      = {{pad_lp{1'b0}}, data_i[winner_w*ring_width_p +: ring_width_p]};
            grant_id_d = winner_w;
            beat_d     = '0;
            state_d    = SEND;
        end else if (accept_w) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            pkt_q       <= '0;
            grant_id_q  <= '0;
            pkt_count_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            pkt_q       <= pkt_d;
            grant_id_q  <= grant_id_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign axis_tvalid_o = (state_q == SEND);
    assign axis_tdata_o  = pkt_q[beat_q*axis_width_p +: axis_width_p];
    assign axis_tlast_o  = last_w;
    assign grant_id_o    = grant_id_q;
    assign pkt_count_o   = pkt_count_q;

endmodule

// File: tb/tb_fsb_host_tx_arbiter.sv
// Random and directed stimulus for fsb_host_tx_arbiter. The reference model holds the
// in-flight packet as a queue of pending words and the arbitration pointer as an integer.
module tb_fsb_host_tx_arbiter;

    localparam int N  = 4;
    localparam int RW = 80;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N-1:0]    v_i;
    logic [N*RW-1:0] data_i;
    logic [N-1:0]    yumi_o;
    logic            axis_tvalid_o;
    logic            axis_tready_i;
    logic [31:0]     axis_tdata_o;
    logic            axis_tlast_o;
    logic [1:0]      grant_id_o;
    logic [31:0]     pkt_count_o;

    always #5 clk = ~clk;

    fsb_host_tx_arbiter #(.num_clients_p(N)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .data_i        (data_i),
        .yumi_o        (yumi_o),
        .axis_tvalid_o (axis_tvalid_o),
        .axis_tready_i (axis_tready_i),
        .axis_tdata_o  (axis_tdata_o),
        .axis_tlast_o  (axis_tlast_o),
        .grant_id_o    (grant_id_o),
        .pkt_count_o   (pkt_count_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [31:0] m_q[$];
    int          m_ptr = 0;
    int          m_gid = 0;
    logic [31:0] m_cnt = 32'd0;

    // observations
    logic [31:0] obs_words[$];
    int          obs_grants[$];
    int          hs_cnt;
    int          yumi_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check at negedge+1, then advance the model
    task automatic step(input logic [N-1:0] v, input logic [N*RW-1:0] d,
                        input logic rdy, input logic rst);
        logic [N-1:0]   exp_y;
        logic [127:0]   padded;
        bit             acc;
        int             w;
        @(negedge clk);
        v_i = v; data_i = d; axis_tready_i = rdy; reset_i = rst;
        #1;
        acc = !rst && (m_q.size() == 0 || (m_q.size() == 1 && rdy));
        w = -1;
        if (acc) begin
            for (int i = 0; i < N; i++) begin
                if (w < 0 && v[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            end
        end
        exp_y = '0;
        if (w >= 0) exp_y[w] = 1'b1;
        check_eq("yumi", yumi_o, exp_y);
        check_eq("tvalid", axis_tvalid_o, m_q.size() != 0);
        check_eq("tlast", axis_tlast_o, m_q.size() == 1);
        check_eq("grant_id", grant_id_o, m_gid);
        check_eq("pkt_count", pkt_count_o, m_cnt);
        if (m_q.size() != 0) check_eq("tdata", axis_tdata_o, m_q[0]);
        if (axis_tvalid_o && rdy) begin
            obs_words.push_back(axis_tdata_o);
            hs_cnt++;
        end
        for (int i = 0; i < N; i++) begin
            if (yumi_o[i]) begin
                obs_grants.push_back(i);
                yumi_seen++;
            end
        end
        if (rst) begin
            m_q.delete(); m_ptr = 0; m_gid = 0; m_cnt = 32'd0;
        end else begin
            if (m_q.size() != 0 && rdy) begin
                if (m_q.size() == 1) m_cnt = m_cnt + 32'd1;
                m_q.delete(0);
            end
            if (w >= 0) begin
                padded = {48'h0, d[w*RW +: RW]};
                m_q.delete();
                for (int b = 0; b < 4; b++) m_q.push_back(padded[b*32 +: 32]);
                m_gid = w;
                m_ptr = (w + 1) % N;
            end
        end
    endtask

    task automatic do_reset();
        step('0, '0, 1'b1, 1'b1);
        step('0, '0, 1'b1, 1'b1);
    endtask

    logic [N*RW-1:0] d;
    logic [79:0]     pkt;

    initial begin
        reset_i = 1'b1; v_i = '0; data_i = '0; axis_tready_i = 1'b0;
        hs_cnt = 0; yumi_seen = 0;
        do_reset();
        step('0, '0, 1'b1, 1'b0);

        // single client
        d = '0; pkt = 80'h1111_2222_3333_4444_5555; d[79:0] = pkt;
        obs_words.delete();
        step(4'b0001, d, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step('0, d, 1'b1, 1'b0);
        check_eq("single_nwords", obs_words.size(), 32'd4);
        if (obs_words.size() == 4) begin
            check_eq("single_w0", obs_words[0], 32'h4444_5555);
            check_eq("single_w1", obs_words[1], 32'h2222_3333);
            check_eq("single_w2", obs_words[2], 32'h0000_1111);
            check_eq("single_w3", obs_words[3], 32'h0000_0000);
        end
        check_eq("single_cnt", pkt_count_o, 32'd1);

        // contention, all clients requesting
        do_reset();
        d = '0;
        for (int k = 0; k < N; k++) d[k*RW +: RW] = RW'(k);
        obs_grants.delete();
        step(4'b1111, d, 1'b1, 1'b0);
        hs_cnt = 0;
        for (int i = 0; i < 16; i++) step(4'b1111, d, 1'b1, 1'b0);
        check_eq("contend_beats", hs_cnt, 32'd16);
        check_eq("contend_ngrants", obs_grants.size(), 32'd5);
        if (obs_grants.size() == 5) begin
            for (int i = 0; i < 5; i++) check_eq("contend_order", obs_grants[i], i % N);
        end
        do_reset();

        // backpressure during beat 1
        d = '0; pkt = 80'hA5A5_0123_4567_89AB_CDEF; d[79:0] = pkt;
        step(4'b0001, d, 1'b1, 1'b0);
        step('0, d, 1'b1, 1'b0);
        yumi_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, d, 1'b0, 1'b0);
            check_eq("stall_tdata", axis_tdata_o, pkt[63:32]);
            check_eq("stall_tlast", axis_tlast_o, 1'b0);
        end
        check_eq("stall_yumi", yumi_seen, 32'd0);
        for (int i = 0; i < 4; i++) step('0, d, 1'b1, 1'b0);
        check_eq("stall_cnt", pkt_count_o, 32'd1);

        // pointer wrap
        do_reset();
        obs_grants.delete();
        step(4'b1000, d, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step('0, d, 1'b1, 1'b0);
        step(4'b1001, d, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step('0, d, 1'b1, 1'b0);
        step(4'b1001, d, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step('0, d, 1'b1, 1'b0);
        check_eq("wrap_n", obs_grants.size(), 32'd3);
        if (obs_grants.size() == 3) begin
            check_eq("wrap_g0", obs_grants[0], 32'd3);
            check_eq("wrap_g1", obs_grants[1], 32'd0);
            check_eq("wrap_g2", obs_grants[2], 32'd3);
        end

        // reset mid-packet at beat 2
        do_reset();
        step(4'b0010, d, 1'b1, 1'b0);
        step('0, d, 1'b1, 1'b0);
        step('0, d, 1'b1, 1'b0);
        step('0, d, 1'b1, 1'b1);
        obs_grants.delete();
        step(4'b0100, d, 1'b1, 1'b0);
        check_eq("rst_tvalid", axis_tvalid_o, 1'b0);
        check_eq("rst_cnt", pkt_count_o, 32'd0);
        check_eq("rst_gid", grant_id_o, 32'd0);
        for (int i = 0; i < 5; i++) step('0, d, 1'b1, 1'b0);
        check_eq("rst_regrant", (obs_grants.size() == 1) ? obs_grants[0] : -1, 32'd2);
        check_eq("rst_after_cnt", pkt_count_o, 32'd1);

        // counter wrap
        @(negedge clk);
        force dut.pkt_count_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.pkt_count_q;
        step(4'b0010, d, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step('0, d, 1'b1, 1'b0);
        check_eq("cnt_wrap", pkt_count_o, 32'd0);

        // random traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N * RW / 32; k++) d[k*32 +: 32] = $urandom;
            step(N'($urandom), d, ($urandom_range(0, 9) < 7), ($urandom_range(0, 127) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
